// File: rtl/imem_arb_pkg.sv
// Shared defaults, response-pipeline entry type and byte-enable helper for the
// instruction SRAM arbiter.
package imem_arb_pkg;

  localparam int AW_DEFAULT  = 12;
  localparam int DW_DEFAULT  = 32;
  localparam int NUM_REQ_MAX = 4;

  // Requester id is sized for the largest supported requester count so the
  // response entry has one fixed layout for every configuration.
  localparam int ID_W = $clog2(NUM_REQ_MAX);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
    logic            we;
  } resp_t;

  // One byte lane of the bit write mask enables that RAM byte if any bit is set.
  function automatic logic wmask_to_be(input logic [7:0] lane_mask);
    return |lane_mask;
  endfunction

endpackage

// File: rtl/imem_arb_rr.sv
// Round-robin arbiter with a lock owner: one-hot grant in the request cycle,
// pointer advances past every granted requester.
module imem_arb_rr
  import imem_arb_pkg::*;
#(
  parameter int NumReq = 2,
  parameter int IdxW   = $clog2(NumReq)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NumReq-1:0] req_i,
  input  logic [NumReq-1:0] lock_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   gnt_idx_o,
  output logic              gnt_vld_o
);

  logic [IdxW-1:0] r_ptr;
  logic [IdxW-1:0] r_owner;
  logic            r_owner_vld;

  logic            w_owner_hold;
  logic [IdxW-1:0] w_cand;

  // Grant selection; a dropped lock is already released for this cycle's pick.
  always_comb begin
    w_owner_hold = r_owner_vld & lock_i[r_owner];
    w_cand       = '0;
    gnt_o        = '0;
    gnt_idx_o    = '0;
    gnt_vld_o    = 1'b0;
    if (rst_i) begin
      gnt_vld_o = 1'b0;
    end else if (w_owner_hold) begin
      if (req_i[r_owner]) begin
        gnt_o[r_owner] = 1'b1;
        gnt_idx_o      = r_owner;
        gnt_vld_o      = 1'b1;
      end
    end else begin
      for (int i = 0; i < NumReq; i++) begin
        w_cand = IdxW'((int'(r_ptr) + i) % NumReq);
        if (!gnt_vld_o && req_i[w_cand]) begin
          gnt_o[w_cand] = 1'b1;
          gnt_idx_o     = w_cand;
          gnt_vld_o     = 1'b1;
        end
      end
    end
  end

  // Pointer and lock-owner update.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr       <= '0;
      r_owner     <= '0;
      r_owner_vld <= 1'b0;
    end else begin
      if (gnt_vld_o) begin
        r_ptr <= (gnt_idx_o == IdxW'(NumReq - 1)) ? '0 : gnt_idx_o + 1'b1;
        if (lock_i[gnt_idx_o]) begin
          r_owner     <= gnt_idx_o;
          r_owner_vld <= 1'b1;
        end else begin
          r_owner_vld <= 1'b0;
        end
      end else if (!w_owner_hold) begin
        r_owner_vld <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/imem_sram_arbiter.sv
// Shares the single-port instruction DFFRAM between requesters: drives the RAM
// from the granted requester and returns completions through a fixed-latency
// response pipeline.
module imem_sram_arbiter
  import imem_arb_pkg::*;
#(
  parameter int NumReq      = 2,
  parameter int Aw          = AW_DEFAULT,
  parameter int Dw          = DW_DEFAULT,
  parameter int ReadLatency = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NumReq-1:0]    req_i,
  input  logic [NumReq-1:0]    we_i,
  input  logic [NumReq-1:0]    lock_i,
  input  logic [NumReq*Aw-1:0] addr_i,
  input  logic [NumReq*Dw-1:0] wdata_i,
  input  logic [NumReq*Dw-1:0] wmask_i,
  output logic [NumReq-1:0]    gnt_o,
  output logic [NumReq-1:0]    rvalid_o,
  output logic [Dw-1:0]        rdata_o,
  output logic                 ram_en_o,
  output logic [Dw/8-1:0]      ram_we_o,
  output logic [Aw-1:0]        ram_addr_o,
  output logic [Dw-1:0]        ram_wdata_o,
  input  logic [Dw-1:0]        ram_rdata_i,
  output logic                 busy_o
);

  localparam int IdxW = $clog2(NumReq);
  localparam int Bw   = Dw / 8;

  logic [NumReq-1:0] w_gnt;
  logic [IdxW-1:0]   w_gnt_idx;
  logic              w_gnt_vld;
  logic              w_we;
  logic [Dw-1:0]     w_wmask;
  logic [Bw-1:0]     w_be;
  logic              w_pipe_busy;
  resp_t             w_ret;
  resp_t             r_pipe [ReadLatency];

  imem_arb_rr #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_rr (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_i),
    .lock_i    (lock_i),
    .gnt_o     (w_gnt),
    .gnt_idx_o (w_gnt_idx),
    .gnt_vld_o (w_gnt_vld)
  );

  // One-hot mux of the granted requester onto the RAM; zeros when idle.
  always_comb begin
    w_we        = 1'b0;
    w_wmask     = '0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    for (int k = 0; k < NumReq; k++) begin
      if (w_gnt[k]) begin
        w_we        = we_i[k];
        w_wmask     = wmask_i[k*Dw +: Dw];
        ram_addr_o  = addr_i[k*Aw +: Aw];
        ram_wdata_o = wdata_i[k*Dw +: Dw];
      end
    end
  end

  for (genvar b = 0; b < Bw; b++) begin : g_be
    assign w_be[b] = wmask_to_be(w_wmask[b*8 +: 8]);
  end

  assign gnt_o    = w_gnt;
  assign ram_en_o = w_gnt_vld;
  assign ram_we_o = w_we ? w_be : '0;

  // Response pipeline: one entry per grant, shifted every cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < ReadLatency; s++) begin
        r_pipe[s] <= '0;
      end
    end else begin
      r_pipe[0] <= {w_gnt_vld, ID_W'(w_gnt_idx), w_we};
      for (int s = 1; s < ReadLatency; s++) begin
        r_pipe[s] <= r_pipe[s-1];
      end
    end
  end

  // Returning entry is masked while reset is held so in-flight work never completes.
  assign w_ret = rst_i ? '0 : r_pipe[ReadLatency-1];

  // Completion strobe decode and pipeline occupancy.
  always_comb begin
    rvalid_o    = '0;
    w_pipe_busy = 1'b0;
    for (int k = 0; k < NumReq; k++) begin
      rvalid_o[k] = w_ret.valid & (w_ret.id == ID_W'(k));
    end
    for (int s = 0; s < ReadLatency; s++) begin
      w_pipe_busy = w_pipe_busy | r_pipe[s].valid;
    end
  end

  assign rdata_o = (w_ret.valid & ~w_ret.we) ? ram_rdata_i : '0;
  assign busy_o  = ~rst_i & (w_pipe_busy | ram_en_o);

endmodule

// File: tb/tb_imem_sram_arbiter.sv
// Directed bench for imem_sram_arbiter: one instance with ReadLatency=1 and a
// behavioural DFFRAM, one with ReadLatency=2 for the reset-in-flight case.
module tb_imem_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        rst2;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [1:0]  lock;
  logic [23:0] addr;
  logic [63:0] wdata;
  logic [63:0] wmask;

  logic [1:0]  gnt, rvalid, gnt2, rvalid2;
  logic [31:0] rdata, rdata2;
  logic        ram_en, ram_en2, busy, busy2;
  logic [3:0]  ram_we, ram_we2;
  logic [11:0] ram_addr, ram_addr2;
  logic [31:0] ram_wdata, ram_wdata2;
  logic [31:0] ram_rdata;
  logic [31:0] ram_rdata2;

  logic [31:0] mem [4096];

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  imem_sram_arbiter #(.NumReq(2), .Aw(12), .Dw(32), .ReadLatency(1)) u_dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .lock_i(lock),
    .addr_i(addr), .wdata_i(wdata), .wmask_i(wmask),
    .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata), .busy_o(busy)
  );

  imem_sram_arbiter #(.NumReq(2), .Aw(12), .Dw(32), .ReadLatency(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst2), .req_i(req), .we_i(we), .lock_i(lock),
    .addr_i(addr), .wdata_i(wdata), .wmask_i(wmask),
    .gnt_o(gnt2), .rvalid_o(rvalid2), .rdata_o(rdata2),
    .ram_en_o(ram_en2), .ram_we_o(ram_we2), .ram_addr_o(ram_addr2),
    .ram_wdata_o(ram_wdata2), .ram_rdata_i(ram_rdata2), .busy_o(busy2)
  );

  assign ram_rdata2 = 32'h5A5A_5A5A;

  // Behavioural DFFRAM: byte writes, registered read data, preload under reset.
  always @(posedge clk) begin
    if (rst) begin
      mem[12'h000] <= 32'h0123_4567;
      mem[12'h010] <= 32'hDEAD_BEEF;
      mem[12'h020] <= 32'hAAAA_AAAA;
      ram_rdata    <= '0;
    end else if (ram_en) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
      if (ram_we == 4'b0000) ram_rdata <= mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    req = '0; we = '0; lock = '0;
    addr = '0; wdata = '0; wmask = '0;

    // Reset held with requests present: everything quiet.
    next_cycle(); req = 2'b11; settle();
    chk("rst_gnt",    gnt,    2'b00);
    chk("rst_en",     ram_en, 1'b0);
    chk("rst_busy",   busy,   1'b0);
    chk("rst_rvalid", rvalid, 2'b00);
    chk("rst_rdata",  rdata,  32'h0);

    // Contention from reset: 01,10,01,10.
    next_cycle(); rst = 1'b0; settle();
    chk("cont0_gnt", gnt, 2'b01);
    chk("cont0_en",  ram_en, 1'b1);
    next_cycle(); settle();
    chk("cont1_gnt",    gnt,    2'b10);
    chk("cont1_rvalid", rvalid, 2'b01);
    chk("cont1_rdata",  rdata,  32'h0123_4567);
    chk("cont1_en",     ram_en, 1'b1);
    next_cycle(); settle();
    chk("cont2_gnt",    gnt,    2'b01);
    chk("cont2_rvalid", rvalid, 2'b10);
    next_cycle(); settle();
    chk("cont3_gnt",    gnt,    2'b10);
    chk("cont3_rvalid", rvalid, 2'b01);
    chk("cont3_en",     ram_en, 1'b1);
    next_cycle(); req = 2'b00; settle();
    chk("cont4_gnt",    gnt,    2'b00);
    chk("cont4_rvalid", rvalid, 2'b10);
    chk("cont4_busy",   busy,   1'b1);

    // Single read by requester 0.
    next_cycle(); req = 2'b01; addr[11:0] = 12'h010; settle();
    chk("rd_gnt",      gnt,      2'b01);
    chk("rd_addr",     ram_addr, 12'h010);
    chk("rd_rvalid0",  rvalid,   2'b00);
    next_cycle(); req = 2'b00; settle();
    chk("rd_rvalid",   rvalid,   2'b01);
    chk("rd_rdata",    rdata,    32'hDEAD_BEEF);

    // Byte write by requester 1, then readback.
    next_cycle();
    req = 2'b10; we = 2'b10; addr[23:12] = 12'h020;
    wdata[63:32] = 32'h1122_3344; wmask[63:32] = 32'h0000_FFFF;
    settle();
    chk("wr_gnt",   gnt,       2'b10);
    chk("wr_we",    ram_we,    4'b0011);
    chk("wr_addr",  ram_addr,  12'h020);
    chk("wr_wdata", ram_wdata, 32'h1122_3344);
    next_cycle(); we = 2'b00; settle();
    chk("wr_rvalid",  rvalid, 2'b10);
    chk("wr_rdata",   rdata,  32'h0);
    chk("rb_gnt",     gnt,    2'b10);
    chk("rb_we",      ram_we, 4'b0000);
    next_cycle(); req = 2'b00; settle();
    chk("rb_rvalid",  rvalid, 2'b10);
    chk("rb_rdata",   rdata,  32'hAAAA_3344);

    // Lock held by requester 1.
    next_cycle(); req = 2'b10; lock = 2'b10; settle();
    chk("lk_gnt0", gnt, 2'b10);
    for (int c = 0; c < 3; c++) begin
      next_cycle(); req = 2'b11; settle();
      chk("lk_hold_gnt", gnt, 2'b10);
    end
    next_cycle(); req = 2'b01; settle();
    chk("lk_block_gnt", gnt,    2'b00);
    chk("lk_block_en",  ram_en, 1'b0);
    next_cycle(); req = 2'b11; lock = 2'b00; settle();
    chk("lk_rel_gnt", gnt, 2'b01);
    next_cycle(); req = 2'b00; settle();
    chk("lk_rel_rvalid", rvalid, 2'b01);

    // Idle after drain, with write-ish inputs present but no request.
    next_cycle(); we = 2'b11; wmask = '1; wdata = '1; settle();
    chk("idle_en",     ram_en,    1'b0);
    chk("idle_we",     ram_we,    4'b0000);
    chk("idle_wdata",  ram_wdata, 32'h0);
    chk("idle_addr",   ram_addr,  12'h000);
    chk("idle_rdata",  rdata,     32'h0);
    chk("idle_rvalid", rvalid,    2'b00);
    chk("idle_busy",   busy,      1'b0);
    we = 2'b00; wmask = '0; wdata = '0;

    // Reset with two reads in flight on the ReadLatency=2 instance.
    next_cycle(); rst2 = 1'b0; req = 2'b01; settle();
    chk("mf_gnt0", gnt2, 2'b01);
    next_cycle(); req = 2'b10; settle();
    chk("mf_gnt1",    gnt2,    2'b10);
    chk("mf_rvalid1", rvalid2, 2'b00);
    next_cycle(); rst2 = 1'b1; req = 2'b11; settle();
    chk("mf_rst_rvalid", rvalid2, 2'b00);
    chk("mf_rst_gnt",    gnt2,    2'b00);
    chk("mf_rst_en",     ram_en2, 1'b0);
    chk("mf_rst_busy",   busy2,   1'b0);
    chk("mf_rst_rdata",  rdata2,  32'h0);
    next_cycle(); req = 2'b00; settle();
    chk("mf_rst2_rvalid", rvalid2, 2'b00);
    next_cycle(); rst2 = 1'b0; req = 2'b11; settle();
    chk("mf_post_gnt",    gnt2,    2'b01);
    chk("mf_post_rvalid", rvalid2, 2'b00);
    next_cycle(); req = 2'b00; settle();
    chk("mf_l1_rvalid", rvalid2, 2'b00);
    chk("mf_l1_busy",   busy2,   1'b1);
    next_cycle(); settle();
    chk("mf_l2_rvalid", rvalid2, 2'b01);
    chk("mf_l2_rdata",  rdata2,  32'h5A5A_5A5A);
    next_cycle(); settle();
    chk("mf_done_rvalid", rvalid2, 2'b00);
    chk("mf_done_busy",   busy2,   1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
